// File: rtl/cache_mem_responder.sv
// Word-addressed main-memory responder for the L1 cache refill/write-back port.
// Closed-line accesses take LATENCY cycles; the next wrap-around word of the same line takes BURST_LATENCY.
module cache_mem_responder #(
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned ADR_WIDTH      = 32,
    parameter int unsigned MEM_DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY        = 4,
    parameter int unsigned BURST_LATENCY  = 1,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req_i,
    input  logic [ADR_WIDTH-1:0]  mem_adr_i,
    input  logic                  mem_we_i,
    input  logic [WORD_WIDTH-1:0] mem_dat_i,
    output logic                  mem_ack_o,
    output logic [WORD_WIDTH-1:0] mem_dat_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  rd_cnt_o,
    output logic [CNT_WIDTH-1:0]  wr_cnt_o
);

    localparam int unsigned Depth = 2 ** MEM_DEPTH_LOG2;
    localparam int unsigned LatW  = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e                r_state;
    logic [LatW-1:0]       r_cnt;
    logic [ADR_WIDTH-3:0]  r_adr;
    logic                  r_we;
    logic [WORD_WIDTH-1:0] r_dat;
    logic                  r_line_open;
    logic [ADR_WIDTH-5:0]  r_line_adr;
    logic [1:0]            r_last_wo;
    logic                  r_last_we;

    logic [WORD_WIDTH-1:0] r_mem [Depth] = '{default: '0};

    logic [MEM_DEPTH_LOG2-1:0] w_idx;
    logic [1:0]                w_next_wo;
    logic                      w_burst;
    logic                      w_done;
    logic                      w_unused;

    assign w_idx     = r_adr[MEM_DEPTH_LOG2-1:0];
    assign w_next_wo = r_last_wo + 2'd1;
    assign w_burst   = r_line_open && (mem_adr_i[ADR_WIDTH-1:4] == r_line_adr)
                       && (mem_adr_i[3:2] == w_next_wo) && (mem_we_i == r_last_we);
    assign w_done    = (r_state == StWait) && mem_req_i && (r_cnt == LatW'(1));
    assign w_unused  = ^mem_adr_i[1:0];

    // Write lands on the ack edge; a reset on that edge discards it.
    always_ff @(posedge clk) begin
        if (!rst && w_done && r_we) begin
            r_mem[w_idx] <= r_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_adr       <= '0;
            r_we        <= 1'b0;
            r_dat       <= '0;
            r_line_open <= 1'b0;
            r_line_adr  <= '0;
            r_last_wo   <= '0;
            r_last_we   <= 1'b0;
            mem_ack_o   <= 1'b0;
            mem_dat_o   <= '0;
            busy_o      <= 1'b0;
            rd_cnt_o    <= '0;
            wr_cnt_o    <= '0;
        end else begin
            mem_ack_o <= 1'b0;
            unique case (r_state)
                // The ack cycle doubles as the turnaround cycle: a request seen at its closing
                // edge is the only one eligible for the open-line latency.
                StIdle, StAck: begin
                    r_line_open <= 1'b0;
                    busy_o      <= mem_req_i;
                    if (mem_req_i) begin
                        r_state <= StWait;
                        r_adr   <= mem_adr_i[ADR_WIDTH-1:2];
                        r_we    <= mem_we_i;
                        r_dat   <= mem_dat_i;
                        r_cnt   <= w_burst ? LatW'(BURST_LATENCY) : LatW'(LATENCY);
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StWait: begin
                    if (!mem_req_i) begin
                        r_state     <= StIdle;
                        busy_o      <= 1'b0;
                        r_line_open <= 1'b0;
                    end else if (r_cnt == LatW'(1)) begin
                        r_state     <= StAck;
                        busy_o      <= 1'b0;
                        mem_ack_o   <= 1'b1;
                        r_line_open <= 1'b1;
                        r_line_adr  <= r_adr[ADR_WIDTH-3:2];
                        r_last_wo   <= r_adr[1:0];
                        r_last_we   <= r_we;
                        if (r_we) begin
                            if (wr_cnt_o != '1) wr_cnt_o <= wr_cnt_o + CNT_WIDTH'(1);
                        end else begin
                            mem_dat_o <= r_mem[w_idx];
                            if (rd_cnt_o != '1) rd_cnt_o <= rd_cnt_o + CNT_WIDTH'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt - LatW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: latency, data, open-line bursts, abort, reset,
// and counter saturation on a second instance with 2-bit counters.
module tb_cache_mem_responder;

    localparam int unsigned Lat  = 4;
    localparam int unsigned BLat = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] dat_i = '0;

    logic        ack, busy, s_ack, s_busy;
    logic [31:0] dat_o, s_dat;
    logic [15:0] rd_cnt, wr_cnt;
    logic [1:0]  s_rd, s_wr;

    cache_mem_responder #(.LATENCY(Lat), .BURST_LATENCY(BLat)) u_dut (
        .clk(clk), .rst(rst), .mem_req_i(req), .mem_adr_i(adr), .mem_we_i(we),
        .mem_dat_i(dat_i), .mem_ack_o(ack), .mem_dat_o(dat_o), .busy_o(busy),
        .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
    );

    cache_mem_responder #(.LATENCY(Lat), .BURST_LATENCY(BLat), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .mem_req_i(req), .mem_adr_i(adr), .mem_we_i(we),
        .mem_dat_i(dat_i), .mem_ack_o(s_ack), .mem_dat_o(s_dat), .busy_o(s_busy),
        .rd_cnt_o(s_rd), .wr_cnt_o(s_wr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [4096];
    logic [31:0] m_last_dat = '0;
    int          last_ack_cyc = -100;
    logic [27:0] last_line = '0;
    logic [1:0]  last_wo = '0;
    logic        last_we = 1'b0;
    logic [31:0] cur_adr = '0;
    logic        cur_we = 1'b0;

    // Drive a request (called at posedge+#1) and predict its ack cycle and data.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
        exp_t       e;
        int         lat;
        int         idx;
        logic [1:0] nwo;
        nwo = last_wo + 2'd1;
        idx = int'(a[13:2]);
        lat = (last_ack_cyc == cyc && a[31:4] == last_line && a[3:2] == nwo && w == last_we)
              ? BLat : Lat;
        e.we  = w;
        e.cyc = cyc + 1 + lat;
        if (w) begin
            e.dat        = m_last_dat;
            ref_mem[idx] = d;
        end else begin
            e.dat      = ref_mem[idx];
            m_last_dat = e.dat;
        end
        sb_q.push_back(e);
        cur_adr = a;
        cur_we  = w;
        req     = 1'b1;
        adr     = a;
        we      = w;
        dat_i   = d;
    endtask

    // Wait for ack, scrambling address/data meanwhile; returns at posedge+#1 of the ack cycle.
    task automatic wait_ack();
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                check("busy_at_ack", {31'b0, busy}, 32'd0);
                last_ack_cyc = cyc;
                last_line    = cur_adr[31:4];
                last_wo      = cur_adr[3:2];
                last_we      = cur_we;
                return;
            end
            check("busy_wait", {31'b0, busy}, 32'd1);
            check("sat_busy_wait", {31'b0, s_busy}, 32'd1);
            adr   = adr ^ 32'h0000_0040;
            dat_i = ~dat_i;
        end
        check("ack_timeout", {31'b0, ack}, 32'd1);
        req = 1'b0;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops the scoreboard on every ack and keeps the counter model.
    int m_rd = 0;
    int m_wr = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            m_rd = 0;
            m_wr = 0;
        end else if (ack) begin
            if (sb_q.size() == 0) begin
                check("spurious_ack", {31'b0, ack}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                if (e.we) m_wr++;
                else      m_rd++;
                check("ack_cycle", 32'(cyc), 32'(e.cyc));
                check("dat", dat_o, e.dat);
                check("rd_cnt", {16'b0, rd_cnt}, 32'(m_rd));
                check("wr_cnt", {16'b0, wr_cnt}, 32'(m_wr));
                check("sat_ack", {31'b0, s_ack}, 32'd1);
                check("sat_dat", s_dat, e.dat);
                check("sat_rd", {30'b0, s_rd}, 32'((m_rd > 3) ? 3 : m_rd));
                check("sat_wr", {30'b0, s_wr}, 32'((m_wr > 3) ? 3 : m_wr));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int order [4];
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        order = '{2, 3, 0, 1};

        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rd_cnt", {16'b0, rd_cnt}, 32'd0);
        check("rst_wr_cnt", {16'b0, wr_cnt}, 32'd0);
        rst = 1'b0;
        idle(1);

        // Plain read of never-written memory, then write followed by read-back.
        issue(32'h100, 1'b0, '0); wait_ack(); idle(1);
        issue(32'h104, 1'b1, 32'hDEAD_BEEF); wait_ack();
        issue(32'h104, 1'b0, '0); wait_ack(); idle(1);

        // Preload a line with a sequential write burst, then critical-word-first refill.
        for (int i = 0; i < 4; i++) begin
            issue(32'h200 + 32'(4 * i), 1'b1, 32'hA0 + 32'(i));
            wait_ack();
        end
        idle(1);
        for (int i = 0; i < 4; i++) begin
            issue(32'h200 + 32'(4 * order[i]), 1'b0, '0);
            wait_ack();
        end
        idle(1);

        // Line change and idle gap both break the open line.
        issue(32'h208, 1'b0, '0); wait_ack();
        issue(32'h300, 1'b0, '0); wait_ack(); idle(1);
        issue(32'h208, 1'b0, '0); wait_ack(); idle(1);
        issue(32'h20C, 1'b0, '0); wait_ack(); idle(1);

        // Abort a write after two cycles.
        req = 1'b1; adr = 32'h110; we = 1'b1; dat_i = 32'h5555_AAAA;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        idle(4);
        check("abort_wr_cnt", {16'b0, wr_cnt}, 32'(m_wr));
        check("abort_busy", {31'b0, busy}, 32'd0);
        issue(32'h110, 1'b0, '0); wait_ack(); idle(1);

        // Reset in the middle of a pending write.
        req = 1'b1; adr = 32'h104; we = 1'b1; dat_i = 32'hBAD0_0BAD;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_last_dat   = '0;
        last_ack_cyc = -100;
        check("midrst_ack", {31'b0, ack}, 32'd0);
        check("midrst_rd_cnt", {16'b0, rd_cnt}, 32'd0);
        check("midrst_wr_cnt", {16'b0, wr_cnt}, 32'd0);
        check("midrst_dat", dat_o, 32'd0);
        idle(2);
        issue(32'h104, 1'b0, '0); wait_ack(); idle(1);

        // Five more reads, including a 3->0 wrap, to saturate the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            issue(32'h200 + 32'(4 * (i % 4)), 1'b0, '0);
            wait_ack();
        end
        idle(2);
        check("final_rd_cnt", {16'b0, rd_cnt}, 32'd6);
        check("final_sat_rd", {30'b0, s_rd}, 32'd3);
        check("final_ack", {31'b0, ack}, 32'd0);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
